// File: rtl/rs_station_multi.sv
// Reservation station: holds dispatched ALU/branch ops until both operands resolve,
// snoops CDB_N result buses for wake-up, and issues the oldest ready op over a
// valid/ready handshake. Age is tracked with an older-than matrix.
module rs_station_multi #(
   parameter int DEPTH_BIT = 3,
   parameter int ROB_BIT   = 5,
   parameter int XLEN      = 32,
   parameter int OP_W      = 7,
   parameter int CDB_N     = 2
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic                     flush_in,
   input  logic                     disp_valid,
   output logic                     disp_ready,
   input  logic [OP_W-1:0]          disp_op,
   input  logic [XLEN-1:0]          disp_vi,
   input  logic [XLEN-1:0]          disp_vj,
   input  logic                     disp_qi_bsy,
   input  logic                     disp_qj_bsy,
   input  logic [ROB_BIT-1:0]       disp_qi,
   input  logic [ROB_BIT-1:0]       disp_qj,
   input  logic [XLEN-1:0]          disp_imm,
   input  logic [XLEN-1:0]          disp_pc,
   input  logic                     disp_itype,
   input  logic [ROB_BIT-1:0]       disp_rob,
   input  logic [CDB_N-1:0]         cdb_valid,
   input  logic [CDB_N*ROB_BIT-1:0] cdb_rob,
   input  logic [CDB_N*XLEN-1:0]    cdb_val,
   output logic                     iss_valid,
   input  logic                     iss_ready,
   output logic [OP_W-1:0]          iss_op,
   output logic [XLEN-1:0]          iss_vi,
   output logic [XLEN-1:0]          iss_vj,
   output logic [XLEN-1:0]          iss_imm,
   output logic [XLEN-1:0]          iss_pc,
   output logic                     iss_itype,
   output logic [ROB_BIT-1:0]       iss_rob,
   output logic [DEPTH_BIT:0]       occupancy
);

   localparam int DEPTH = 1 << DEPTH_BIT;

   typedef struct packed {
      logic               valid;
      logic [OP_W-1:0]    op;
      logic [XLEN-1:0]    vi;
      logic [XLEN-1:0]    vj;
      logic               qi_bsy;
      logic               qj_bsy;
      logic [ROB_BIT-1:0] qi;
      logic [ROB_BIT-1:0] qj;
      logic [XLEN-1:0]    imm;
      logic [XLEN-1:0]    pc;
      logic               itype;
      logic [ROB_BIT-1:0] rob;
   } entry_t;

   entry_t             ent_q   [DEPTH];
   entry_t             ent_d   [DEPTH];
   // older_q[j][i] = 1 means entry j was dispatched before entry i
   logic [DEPTH-1:0]   older_q [DEPTH];
   logic [DEPTH-1:0]   older_d [DEPTH];

   logic               iss_valid_q, iss_valid_d;
   logic [OP_W-1:0]    iss_op_q, iss_op_d;
   logic [XLEN-1:0]    iss_vi_q, iss_vi_d, iss_vj_q, iss_vj_d;
   logic [XLEN-1:0]    iss_imm_q, iss_imm_d, iss_pc_q, iss_pc_d;
   logic               iss_itype_q, iss_itype_d;
   logic [ROB_BIT-1:0] iss_rob_q, iss_rob_d;

   logic [DEPTH-1:0]     elig;
   logic [DEPTH-1:0]     pick;
   logic [DEPTH_BIT-1:0] sel_idx;
   logic [DEPTH_BIT-1:0] free_idx;
   logic [DEPTH_BIT:0]   occ_cnt;

   // Returns {hit, value}; the lowest-numbered matching channel wins.
   function automatic logic [XLEN:0] cdb_lookup(input logic [ROB_BIT-1:0] tag,
                                                input logic [CDB_N-1:0] vld,
                                                input logic [CDB_N*ROB_BIT-1:0] tags,
                                                input logic [CDB_N*XLEN-1:0] vals);
      logic [XLEN:0] r;
      r = '0;
      for (int k = CDB_N - 1; k >= 0; k--) begin
         if (vld[k] && tags[k*ROB_BIT +: ROB_BIT] == tag) r = {1'b1, vals[k*XLEN +: XLEN]};
      end
      return r;
   endfunction

   // An entry is pickable when eligible and no other eligible entry is older than it
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pick
         logic [DEPTH-1:0] col;
         for (genvar gj = 0; gj < DEPTH; gj++) begin : g_col
            assign col[gj] = older_q[gj][gi];
         end
         assign elig[gi] = ent_q[gi].valid && !ent_q[gi].qi_bsy && !ent_q[gi].qj_bsy;
         assign pick[gi] = elig[gi] && !(|(elig & col));
      end
   endgenerate

   // Encode the picked entry, the lowest free slot, and the live entry count
   always_comb begin
      sel_idx  = '0;
      free_idx = '0;
      occ_cnt  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (pick[i])         sel_idx  = DEPTH_BIT'(i);
         if (!ent_q[i].valid) free_idx = DEPTH_BIT'(i);
      end
      for (int i = 0; i < DEPTH; i++) occ_cnt = occ_cnt + (DEPTH_BIT+1)'(ent_q[i].valid);
   end

   assign occupancy  = occ_cnt;
   assign disp_ready = occ_cnt < (DEPTH_BIT+1)'(DEPTH);

   // Next state: wake-up, issue and dispatch all happen in the same cycle
   always_comb begin
      entry_t        new_ent;
      logic [XLEN:0] hit;
      ent_d       = ent_q;
      older_d     = older_q;
      iss_valid_d = iss_valid_q;
      iss_op_d    = iss_op_q;
      iss_vi_d    = iss_vi_q;
      iss_vj_d    = iss_vj_q;
      iss_imm_d   = iss_imm_q;
      iss_pc_d    = iss_pc_q;
      iss_itype_d = iss_itype_q;
      iss_rob_d   = iss_rob_q;
      new_ent     = '0;
      hit         = '0;
      if (rdy_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && ent_q[i].qi_bsy) begin
               hit = cdb_lookup(ent_q[i].qi, cdb_valid, cdb_rob, cdb_val);
               if (hit[XLEN]) begin
                  ent_d[i].vi     = hit[XLEN-1:0];
                  ent_d[i].qi_bsy = 1'b0;
               end
            end
            if (ent_q[i].valid && ent_q[i].qj_bsy) begin
               hit = cdb_lookup(ent_q[i].qj, cdb_valid, cdb_rob, cdb_val);
               if (hit[XLEN]) begin
                  ent_d[i].vj     = hit[XLEN-1:0];
                  ent_d[i].qj_bsy = 1'b0;
               end
            end
         end
         if (!iss_valid_q || iss_ready) begin
            if (|pick) begin
               iss_valid_d              = 1'b1;
               iss_op_d                 = ent_q[sel_idx].op;
               iss_vi_d                 = ent_q[sel_idx].vi;
               iss_vj_d                 = ent_q[sel_idx].vj;
               iss_imm_d                = ent_q[sel_idx].imm;
               iss_pc_d                 = ent_q[sel_idx].pc;
               iss_itype_d              = ent_q[sel_idx].itype;
               iss_rob_d                = ent_q[sel_idx].rob;
               ent_d[sel_idx].valid     = 1'b0;
            end else begin
               iss_valid_d = 1'b0;
            end
         end
         if (disp_valid && disp_ready) begin
            new_ent.valid  = 1'b1;
            new_ent.op     = disp_op;
            new_ent.vi     = disp_vi;
            new_ent.vj     = disp_vj;
            new_ent.qi_bsy = disp_qi_bsy;
            new_ent.qj_bsy = disp_qj_bsy;
            new_ent.qi     = disp_qi;
            new_ent.qj     = disp_qj;
            new_ent.imm    = disp_imm;
            new_ent.pc     = disp_pc;
            new_ent.itype  = disp_itype;
            new_ent.rob    = disp_rob;
            hit = cdb_lookup(disp_qi, cdb_valid, cdb_rob, cdb_val);
            if (disp_qi_bsy && hit[XLEN]) begin
               new_ent.vi     = hit[XLEN-1:0];
               new_ent.qi_bsy = 1'b0;
            end
            hit = cdb_lookup(disp_qj, cdb_valid, cdb_rob, cdb_val);
            if (disp_qj_bsy && hit[XLEN]) begin
               new_ent.vj     = hit[XLEN-1:0];
               new_ent.qj_bsy = 1'b0;
            end
            ent_d[free_idx]   = new_ent;
            // The new entry is older than nobody and younger than every live entry
            older_d[free_idx] = '0;
            for (int j = 0; j < DEPTH; j++) older_d[j][free_idx] = ent_q[j].valid;
         end
      end
   end

   // State registers; flush returns everything to the reset state
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in || flush_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i]   <= '0;
            older_q[i] <= '0;
         end
         iss_valid_q <= 1'b0;
         iss_op_q    <= '0;
         iss_vi_q    <= '0;
         iss_vj_q    <= '0;
         iss_imm_q   <= '0;
         iss_pc_q    <= '0;
         iss_itype_q <= 1'b0;
         iss_rob_q   <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i]   <= ent_d[i];
            older_q[i] <= older_d[i];
         end
         iss_valid_q <= iss_valid_d;
         iss_op_q    <= iss_op_d;
         iss_vi_q    <= iss_vi_d;
         iss_vj_q    <= iss_vj_d;
         iss_imm_q   <= iss_imm_d;
         iss_pc_q    <= iss_pc_d;
         iss_itype_q <= iss_itype_d;
         iss_rob_q   <= iss_rob_d;
      end
   end

   assign iss_valid = iss_valid_q;
   assign iss_op    = iss_op_q;
   assign iss_vi    = iss_vi_q;
   assign iss_vj    = iss_vj_q;
   assign iss_imm   = iss_imm_q;
   assign iss_pc    = iss_pc_q;
   assign iss_itype = iss_itype_q;
   assign iss_rob   = iss_rob_q;

endmodule

// File: tb/tb_rs_station_multi.sv
// Bench for rs_station_multi: age-ordered behavioural model checked every cycle,
// plus directed scenarios with literal expectations on issue order and values.
module tb_rs_station_multi;

   localparam int DB = 3, RB = 5, XL = 32, OW = 7, CN = 2, D = 8;

   logic            clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, flush_in = 1'b0;
   logic            disp_valid = 1'b0, disp_ready;
   logic [OW-1:0]   disp_op = '0;
   logic [XL-1:0]   disp_vi = '0, disp_vj = '0, disp_imm = '0, disp_pc = '0;
   logic            disp_qi_bsy = 1'b0, disp_qj_bsy = 1'b0, disp_itype = 1'b0;
   logic [RB-1:0]   disp_qi = '0, disp_qj = '0, disp_rob = '0;
   logic [CN-1:0]   cdb_valid = '0;
   logic [CN*RB-1:0] cdb_rob = '0;
   logic [CN*XL-1:0] cdb_val = '0;
   logic            iss_valid, iss_ready = 1'b1, iss_itype;
   logic [OW-1:0]   iss_op;
   logic [XL-1:0]   iss_vi, iss_vj, iss_imm, iss_pc;
   logic [RB-1:0]   iss_rob;
   logic [DB:0]     occupancy;

   rs_station_multi dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
      .disp_vi(disp_vi), .disp_vj(disp_vj), .disp_qi_bsy(disp_qi_bsy),
      .disp_qj_bsy(disp_qj_bsy), .disp_qi(disp_qi), .disp_qj(disp_qj),
      .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_itype(disp_itype),
      .disp_rob(disp_rob), .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_val(cdb_val),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_vi(iss_vi),
      .iss_vj(iss_vj), .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_itype(iss_itype),
      .iss_rob(iss_rob), .occupancy(occupancy)
   );

   always #5 clk_in = ~clk_in;

   int tests = 0, fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: entries carry a dispatch sequence number ----
   bit            m_valid [D];
   bit            m_bi [D], m_bj [D], m_it [D];
   logic [OW-1:0] m_op [D];
   logic [XL-1:0] m_vi [D], m_vj [D], m_imm [D], m_pc [D];
   logic [RB-1:0] m_qi [D], m_qj [D], m_rob [D];
   int            m_seq [D];
   int            seq_ctr;
   bit            e_iv, e_it;
   logic [OW-1:0] e_op;
   logic [XL-1:0] e_vi, e_vj, e_imm, e_pc;
   logic [RB-1:0] e_rob;

   function automatic logic [XL:0] bus_find(input logic [RB-1:0] tag);
      for (int k = 0; k < CN; k++)
         if (cdb_valid[k] && cdb_rob[k*RB +: RB] == tag) return {1'b1, cdb_val[k*XL +: XL]};
      return '0;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < D; i++) m_valid[i] = 0;
      e_iv = 0; e_it = 0; e_op = '0; e_vi = '0; e_vj = '0; e_imm = '0; e_pc = '0; e_rob = '0;
      seq_ctr = 0;
   endtask

   task automatic model_step();
      int sel, slot, cnt;
      logic [XL:0] h;
      sel = -1; slot = -1; cnt = 0;
      for (int i = 0; i < D; i++) begin
         if (m_valid[i]) cnt++;
         if (!m_valid[i] && slot < 0) slot = i;
         if (m_valid[i] && !m_bi[i] && !m_bj[i] && (sel < 0 || m_seq[i] < m_seq[sel])) sel = i;
      end
      for (int i = 0; i < D; i++) if (m_valid[i]) begin
         h = bus_find(m_qi[i]);
         if (m_bi[i] && h[XL]) begin m_bi[i] = 0; m_vi[i] = h[XL-1:0]; end
         h = bus_find(m_qj[i]);
         if (m_bj[i] && h[XL]) begin m_bj[i] = 0; m_vj[i] = h[XL-1:0]; end
      end
      if (!e_iv || iss_ready) begin
         if (sel >= 0) begin
            e_iv = 1; e_op = m_op[sel]; e_vi = m_vi[sel]; e_vj = m_vj[sel];
            e_imm = m_imm[sel]; e_pc = m_pc[sel]; e_it = m_it[sel]; e_rob = m_rob[sel];
            m_valid[sel] = 0;
         end else e_iv = 0;
      end
      if (disp_valid && cnt < D) begin
         m_valid[slot] = 1; m_op[slot] = disp_op; m_imm[slot] = disp_imm; m_pc[slot] = disp_pc;
         m_it[slot] = disp_itype; m_rob[slot] = disp_rob; m_qi[slot] = disp_qi; m_qj[slot] = disp_qj;
         m_vi[slot] = disp_vi; m_vj[slot] = disp_vj; m_bi[slot] = disp_qi_bsy; m_bj[slot] = disp_qj_bsy;
         h = bus_find(disp_qi);
         if (disp_qi_bsy && h[XL]) begin m_bi[slot] = 0; m_vi[slot] = h[XL-1:0]; end
         h = bus_find(disp_qj);
         if (disp_qj_bsy && h[XL]) begin m_bj[slot] = 0; m_vj[slot] = h[XL-1:0]; end
         m_seq[slot] = seq_ctr++;
      end
   endtask

   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in || flush_in) model_clear();
      else if (rdy_in) model_step();
   end

   // Compare DUT against model on every falling edge while out of reset
   always @(negedge clk_in) begin
      int cnt;
      if (rst_in) begin
         cnt = 0;
         for (int i = 0; i < D; i++) if (m_valid[i]) cnt++;
         chk("iss_valid", 64'(iss_valid), 64'(e_iv));
         chk("occupancy", 64'(occupancy), 64'(cnt));
         chk("disp_ready", 64'(disp_ready), 64'(cnt < D));
         chk("iss_op", 64'(iss_op), 64'(e_op));
         chk("iss_vi", 64'(iss_vi), 64'(e_vi));
         chk("iss_vj", 64'(iss_vj), 64'(e_vj));
         chk("iss_imm", 64'(iss_imm), 64'(e_imm));
         chk("iss_pc", 64'(iss_pc), 64'(e_pc));
         chk("iss_itype", 64'(iss_itype), 64'(e_it));
         chk("iss_rob", 64'(iss_rob), 64'(e_rob));
      end
   end

   // Log of ops actually accepted by the ALU side
   int            log_rob [$];
   logic [XL-1:0] log_vi [$], log_vj [$];
   always @(posedge clk_in) begin
      if (rst_in && !flush_in && rdy_in && iss_valid && iss_ready) begin
         log_rob.push_back(int'(iss_rob)); log_vi.push_back(iss_vi); log_vj.push_back(iss_vj);
         $display("[TB] issue rob=%0d vi=%0h vj=%0h", iss_rob, iss_vi, iss_vj);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(negedge clk_in); #1;
   endtask

   task automatic idle();
      disp_valid = 0; cdb_valid = '0; flush_in = 0;
   endtask

   task automatic disp(input logic [RB-1:0] rob, input logic [XL-1:0] vi, input logic [XL-1:0] vj,
                       input bit bi, input logic [RB-1:0] qi, input bit bj, input logic [RB-1:0] qj);
      disp_valid = 1; disp_rob = rob; disp_op = OW'(rob) + 7'd1;
      disp_vi = vi; disp_vj = vj; disp_qi_bsy = bi; disp_qi = qi; disp_qj_bsy = bj; disp_qj = qj;
      disp_imm = 32'h100 + 32'(rob); disp_pc = 32'h1000 + 32'(rob) * 4; disp_itype = rob[0];
   endtask

   task automatic cdb(input int k, input logic [RB-1:0] tag, input logic [XL-1:0] v);
      cdb_valid[k] = 1'b1; cdb_rob[k*RB +: RB] = tag; cdb_val[k*XL +: XL] = v;
   endtask

   task automatic drain(input int n);
      idle(); iss_ready = 1;
      repeat (n) step();
   endtask

   task automatic clear_log();
      log_rob.delete(); log_vi.delete(); log_vj.delete();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step(); step();
      chk("reset_occ", 64'(occupancy), 64'd0);
      chk("reset_ready", 64'(disp_ready), 64'd1);
      chk("reset_iss_valid", 64'(iss_valid), 64'd0);
      rst_in = 1; step();

      // Ordering: busy op waits for CDB while younger ready ops go first
      clear_log();
      disp(5'd3, 32'h0, 32'h5, 1, 5'd9, 0, 5'd0); step();
      disp(5'd4, 32'h1, 32'h2, 0, 5'd0, 0, 5'd0); step();
      disp(5'd5, 32'h3, 32'h4, 0, 5'd0, 0, 5'd0); step();
      idle(); step();
      cdb(0, 5'd9, 32'h11); step();
      drain(5);
      chk("t2_count", 64'(log_rob.size()), 64'd3);
      if (log_rob.size() == 3) begin
         chk("t2_first", 64'(log_rob[0]), 64'd4);
         chk("t2_second", 64'(log_rob[1]), 64'd5);
         chk("t2_third", 64'(log_rob[2]), 64'd3);
         chk("t2_woken_vi", 64'(log_vi[2]), 64'h11);
      end

      // Same-cycle CDB bypass into a dispatching op
      clear_log();
      disp(5'd10, 32'h3, 32'h0, 0, 5'd0, 1, 5'd7); cdb(1, 5'd7, 32'hDEAD); step();
      idle(); step();
      chk("t3_valid", 64'(iss_valid), 64'd1);
      chk("t3_vj", 64'(iss_vj), 64'hDEAD);
      drain(3);

      // Two channels carrying the same tag: channel 0 wins
      clear_log();
      disp(5'd11, 32'h0, 32'h6, 1, 5'd12, 0, 5'd0); step();
      idle(); cdb(0, 5'd12, 32'hAAAA); cdb(1, 5'd12, 32'hBBBB); step();
      drain(4);
      chk("multi_cdb_count", 64'(log_rob.size()), 64'd1);
      if (log_rob.size() == 1) chk("multi_cdb_vi", 64'(log_vi[0]), 64'hAAAA);

      // Full station with the ALU stalled, then drain in age order
      clear_log();
      iss_ready = 0;
      for (int i = 0; i < 9; i++) begin
         disp(5'(16 + i), 32'(i * 3), 32'(i), 0, 5'd0, 0, 5'd0); step();
      end
      idle();
      chk("t4_full_ready", 64'(disp_ready), 64'd0);
      chk("t4_full_occ", 64'(occupancy), 64'd8);
      chk("t4_head", 64'(iss_rob), 64'd16);
      disp(5'd25, 32'h9, 32'h9, 0, 5'd0, 0, 5'd0); step();
      drain(12);
      chk("t4_count", 64'(log_rob.size()), 64'd9);
      for (int i = 0; i < 9 && i < log_rob.size(); i++) chk("t4_order", 64'(log_rob[i]), 64'(16 + i));

      // Flush with a queue of work and a concurrent dispatch
      iss_ready = 0;
      for (int i = 0; i < 6; i++) begin
         disp(5'(i), 32'(i), 32'(i), 0, 5'd0, i[0], 5'd20); step();
      end
      disp(5'd30, 32'h1, 32'h1, 0, 5'd0, 0, 5'd0); flush_in = 1; step();
      idle();
      chk("t5_occ", 64'(occupancy), 64'd0);
      chk("t5_iss_valid", 64'(iss_valid), 64'd0);
      chk("t5_ready", 64'(disp_ready), 64'd1);
      drain(2);

      // Global stall: dispatch and CDB ignored, outputs hold
      clear_log();
      iss_ready = 1;
      disp(5'd1, 32'h0, 32'h8, 1, 5'd20, 0, 5'd0); step();
      iss_ready = 0;
      disp(5'd2, 32'h2, 32'h2, 0, 5'd0, 0, 5'd0); step();
      idle(); step();
      rdy_in = 0; iss_ready = 1;
      disp(5'd3, 32'h3, 32'h3, 0, 5'd0, 0, 5'd0); cdb(0, 5'd20, 32'h77);
      repeat (3) step();
      chk("t6_occ", 64'(occupancy), 64'd1);
      chk("t6_iss_valid", 64'(iss_valid), 64'd1);
      chk("t6_iss_rob", 64'(iss_rob), 64'd2);
      rdy_in = 1; idle(); cdb(1, 5'd20, 32'h55); step();
      drain(4);
      chk("t6_count", 64'(log_rob.size()), 64'd2);
      if (log_rob.size() == 2) begin
         chk("t6_first", 64'(log_rob[0]), 64'd2);
         chk("t6_second", 64'(log_rob[1]), 64'd1);
         chk("t6_vi", 64'(log_vi[1]), 64'h55);
      end

      // Mixed traffic checked cycle by cycle against the model
      for (int c = 0; c < 120; c++) begin
         idle();
         iss_ready = 1'($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) != 0)
            disp(5'(c), $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
         if ($urandom_range(0, 1) != 0) cdb(0, 5'($urandom_range(0, 7)), $urandom);
         if ($urandom_range(0, 1) != 0) cdb(1, 5'($urandom_range(0, 7)), $urandom);
         rdy_in = 1'($urandom_range(0, 7) != 0);
         step();
      end
      rdy_in = 1;

      // Asynchronous reset in the middle of traffic
      rst_in = 0; #1;
      chk("t1_iss_valid", 64'(iss_valid), 64'd0);
      chk("t1_occ", 64'(occupancy), 64'd0);
      chk("t1_ready", 64'(disp_ready), 64'd1);
      idle(); step();
      rst_in = 1; step(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
